reg_file_staged: RTL and testbench

- Parametrised register file with one write port and two asynchronous read ports; the next-generation register file for the datapath.
- The write address passes through a parametrised binary-to-one-hot decoder and is registered into a one-entry write stage. The write commits to the storage array on the following clock edge.
- Optional hard-wired zero register (RISC-style x0) and optional read bypass from the staged write.

---
 rtl/rf_pkg.sv | 6 +
 rtl/onehot_decoder.sv | 18 +
 rtl/reg_file_staged.sv | 72 +++++++
 tb/tb_reg_file_staged.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults for the staged register file
package rf_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int ZERO_IDX           = 0;
endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - binary address to one-hot enable decoder
module onehot_decoder
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  en_i,
  output logic [DEPTH-1:0]      onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/reg_file_staged.sv
// rtl/reg_file_staged.sv - 1W/2R register file with a one-entry write stage
// Optional same-cycle read bypass of the staged write under RF_BYPASS_EN.
module reg_file_staged
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b_i,
  output logic [DATA_WIDTH-1:0] rd_data_a_o,
  output logic [DATA_WIDTH-1:0] rd_data_b_o,
  output logic [DEPTH-1:0]      wr_onehot_o,
  output logic                  wr_pending_o
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_IDX);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      dec_onehot;
  logic                  dec_en;
  logic                  stage_valid;
  logic [DEPTH-1:0]      stage_onehot;
  logic [DATA_WIDTH-1:0] stage_data;

  // Writes to the hard-wired zero register never reach the stage.
  assign dec_en = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == ZERO_ADDR));

  onehot_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
    .addr_i   (wr_addr_i),
    .en_i     (dec_en),
    .onehot_o (dec_onehot)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      stage_valid  <= 1'b0;
      stage_onehot <= '0;
      stage_data   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (stage_onehot[i]) mem[i] <= stage_data;
      end
      stage_valid  <= dec_en;
      stage_onehot <= dec_onehot;
      stage_data   <= wr_data_i;
    end
  end

  assign wr_onehot_o  = stage_onehot;
  assign wr_pending_o = stage_valid;

  always_comb begin
    rd_data_a_o = mem[rd_addr_a_i];
    rd_data_b_o = mem[rd_addr_b_i];
`ifdef RF_BYPASS_EN
    if (stage_onehot[rd_addr_a_i]) rd_data_a_o = stage_data;
    if (stage_onehot[rd_addr_b_i]) rd_data_b_o = stage_data;
`endif
    if ((ZERO_REG != 0) && (rd_addr_a_i == ZERO_ADDR)) rd_data_a_o = '0;
    if ((ZERO_REG != 0) && (rd_addr_b_i == ZERO_ADDR)) rd_data_b_o = '0;
  end

endmodule

// File: tb/tb_reg_file_staged.sv
// tb/tb_reg_file_staged.sv - self-checking bench for reg_file_staged
module tb_reg_file_staged;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  ra = '0;
  logic [4:0]  rb = '0;
  logic [31:0] rd_a, rd_b, onehot;
  logic        pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_staged dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .rd_addr_a_i  (ra),
    .rd_addr_b_i  (rb),
    .rd_data_a_o  (rd_a),
    .rd_data_b_o  (rd_b),
    .wr_onehot_o  (onehot),
    .wr_pending_o (pending)
  );

  // Reference: architectural registers plus at most one write in flight.
  logic [31:0] m_regs [32];
  bit          m_pend = 0;
  int          m_addr = 0;
  logic [31:0] m_data = '0;
  bit          m_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pend = 0;
      m_live = 1;
    end else begin
      if (m_pend) m_regs[m_addr] = m_data;
      m_pend = wr_en && (wr_addr != 0);
      m_addr = int'(wr_addr);
      m_data = wr_data;
    end
  end

  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (m_pend && m_addr == a) return m_data;
`endif
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      check("model_rd_a", rd_a, exp_read(int'(ra)));
      check("model_rd_b", rd_b, exp_read(int'(rb)));
      check("model_onehot", onehot, m_pend ? (32'h1 << m_addr) : 32'h0);
      check("model_pending", {31'h0, pending}, {31'h0, m_pend});
    end
  end

  task automatic drive(input bit r, input bit en, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] xa, input logic [4:0] xb);
    @(posedge clk);
    #1;
    rst = r; wr_en = en; wr_addr = a; wr_data = d; ra = xa; rb = xb;
    #1;
  endtask

  initial begin
    logic [31:0] hz;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 31);
    check("reset_onehot", onehot, 32'h0);
    check("reset_pending", {31'h0, pending}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
      check("reset_rd_a", rd_a, 32'h0);
      check("reset_rd_b", rd_b, 32'h0);
    end

    drive(0, 1, 5, 32'hDEADBEEF, 0, 0);
    drive(0, 0, 0, 0, 5, 4);
    check("single_onehot", onehot, 32'h0000_0020);
    check("single_pending", {31'h0, pending}, 32'h1);
    drive(0, 0, 0, 0, 5, 4);
    check("single_rd_a", rd_a, 32'hDEADBEEF);
    check("single_rd_b", rd_b, 32'h0);

    drive(0, 1, 0, 32'h12345678, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("zero_onehot", onehot, 32'h0);
    check("zero_pending", {31'h0, pending}, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    check("zero_rd_a", rd_a, 32'h0);

    drive(0, 1, 3, 32'h11, 0, 0);
    drive(0, 1, 3, 32'h22, 0, 0);
    check("b2b_onehot0", onehot, 32'h8);
    drive(0, 1, 31, 32'hFF, 0, 0);
    check("b2b_onehot1", onehot, 32'h8);
    drive(0, 0, 0, 0, 3, 31);
    check("b2b_onehot2", onehot, 32'h8000_0000);
    drive(0, 0, 0, 0, 3, 31);
    check("b2b_rd3", rd_a, 32'h22);
    check("b2b_rd31", rd_b, 32'hFF);

`ifdef RF_BYPASS_EN
    hz = 32'hA5A5A5A5;
`else
    hz = 32'h0;
`endif
    drive(0, 1, 7, 32'hA5A5A5A5, 0, 0);
    drive(0, 0, 0, 0, 7, 7);
    check("hazard_rd_a", rd_a, hz);
    check("hazard_rd_b", rd_b, hz);
    drive(0, 0, 0, 0, 7, 7);
    check("hazard_commit", rd_a, 32'hA5A5A5A5);

    drive(0, 1, 9, 32'h55, 9, 9);
    drive(1, 0, 0, 0, 9, 9);
    check("midrst_pending_before", {31'h0, pending}, 32'h1);
    drive(0, 0, 0, 0, 9, 7);
    check("midrst_pending", {31'h0, pending}, 32'h0);
    check("midrst_rd9", rd_a, 32'h0);
    check("midrst_rd7", rd_b, 32'h0);
    drive(0, 0, 0, 0, 9, 9);
    check("midrst_rd9_later", rd_a, 32'h0);

    for (int n = 0; n < 2000; n++) begin
      logic [4:0] wa;
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 6), wa, 32'($urandom),
            ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom),
            ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom));
    end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
